ethernet_packet_transmitter: RTL and testbench

// - Transmit-side counterpart of the port's receive path (nibble->byte packager + packet parser).
// - Accepts payload bytes over a ready/enable handshake; emits a nibble-wide MII-style stream:

---
 rtl/ethernet_package.sv | 23 ++
 rtl/ethernet_crc32_byte.sv | 29 ++
 rtl/ethernet_packet_transmitter.sv | 198 +++++++++++++++++++
 tb/tb_ethernet_packet_transmitter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_package.sv
// Shared transmit/receive definitions for the Ethernet port: FSM states, framing
// nibbles and the byte-wise reflected CRC-32 step.
package ethernet_package;

    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG} tx_state_t;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
    localparam logic [31:0] CRC32_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;

    // Reflected CRC-32: fold the byte into the low bits, then shift LSB-first.
    function automatic logic [31:0] crc32_next_byte(input logic [31:0] crc,
                                                    input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ethernet_crc32_byte.sv
// Registered CRC-32 accumulator, one byte per update strobe; init has priority.
module ethernet_crc32_byte
    import ethernet_package::*;
(
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_init,
    input  logic        i_update,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    assign w_crc_next = crc32_next_byte(r_crc, i_data);
    assign o_crc      = r_crc;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_crc <= CRC32_INIT;
        end else if (i_init) begin
            r_crc <= CRC32_INIT;
        end else if (i_update) begin
            r_crc <= w_crc_next;
        end
    end

endmodule

// File: rtl/ethernet_packet_transmitter.sv
// Nibble-wide MII-style frame transmitter: preamble/SFD, payload, zero pad, FCS, IFG.
module ethernet_packet_transmitter
    import ethernet_package::*;
#(
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned MAX_FRAME_BYTES = 1514,
    parameter int unsigned IFG_NIBBLES     = 24
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic [8:0] i_transmit_data,
    input  logic       i_transmit_data_enable,
    output logic       o_transmit_data_ready,
    output logic [3:0] o_phy_transmit_data,
    output logic       o_phy_transmit_data_valid,
    output logic       o_frame_done,
    output logic       o_frame_abort
);

    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME_BYTES);
    localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES - 1);

    tx_state_t   r_state, w_state_d;
    logic [8:0]  r_hold, w_hold_d;
    logic [10:0] r_byte_count, w_byte_count_d, w_byte_inc;
    logic        r_phase, w_phase_d;
    logic [15:0] r_count, w_count_d;
    logic [3:0]  r_phy_data, w_nibble_d;
    logic        r_phy_valid, w_valid_d;
    logic        r_done, w_done_d;
    logic        r_abort, w_abort_d;
    logic        w_transfer;
    logic        w_crc_init, w_crc_update;
    logic [7:0]  w_crc_data;
    logic [31:0] w_crc, w_fcs;

    ethernet_crc32_byte u_crc (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_init    (w_crc_init),
        .i_update  (w_crc_update),
        .i_data    (w_crc_data),
        .o_crc     (w_crc)
    );

    assign o_transmit_data_ready = ((r_state == IDLE) && i_enable) ||
                                   ((r_state == PAYLOAD) && r_phase && !r_hold[8]);
    assign w_transfer = o_transmit_data_ready && i_transmit_data_enable;
    assign w_byte_inc = (r_byte_count == '1) ? r_byte_count : r_byte_count + 11'd1;
    assign w_fcs      = ~w_crc;

    always_comb begin
        w_state_d      = r_state;
        w_hold_d       = r_hold;
        w_byte_count_d = r_byte_count;
        w_phase_d      = r_phase;
        w_count_d      = r_count;
        w_crc_init     = 1'b0;
        w_crc_update   = 1'b0;
        w_crc_data     = i_transmit_data[7:0];
        w_abort_d      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_transfer) begin
                    w_hold_d       = i_transmit_data;
                    w_byte_count_d = 11'd1;
                    w_crc_update   = 1'b1;
                    w_count_d      = 16'd0;
                    w_state_d      = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (r_count == 16'd15) begin
                    w_state_d = PAYLOAD;
                    w_phase_d = 1'b0;
                    w_count_d = 16'd0;
                end else begin
                    w_count_d = r_count + 16'd1;
                end
            end
            PAYLOAD: begin
                if (!r_phase) begin
                    w_phase_d = 1'b1;
                end else if (r_hold[8]) begin
                    if (r_byte_count < MIN_CNT) begin
                        // The first pad byte is counted and folded into the CRC on entry.
                        w_state_d      = PAD;
                        w_phase_d      = 1'b0;
                        w_byte_count_d = w_byte_inc;
                        w_crc_update   = 1'b1;
                        w_crc_data     = 8'h00;
                    end else begin
                        w_state_d = FCS;
                        w_count_d = 16'd0;
                    end
                end else if (w_transfer && (r_byte_count < MAX_CNT)) begin
                    w_hold_d       = i_transmit_data;
                    w_byte_count_d = w_byte_inc;
                    w_crc_update   = 1'b1;
                    w_phase_d      = 1'b0;
                end else begin
                    // Underrun, or an oversize byte that is consumed but never sent.
                    w_state_d = IFG;
                    w_count_d = 16'd0;
                    w_abort_d = 1'b1;
                end
            end
            PAD: begin
                if (!r_phase) begin
                    w_phase_d = 1'b1;
                end else if (r_byte_count >= MIN_CNT) begin
                    w_state_d = FCS;
                    w_count_d = 16'd0;
                end else begin
                    w_byte_count_d = w_byte_inc;
                    w_crc_update   = 1'b1;
                    w_crc_data     = 8'h00;
                    w_phase_d      = 1'b0;
                end
            end
            FCS: begin
                if (r_count == 16'd7) begin
                    w_state_d = IFG;
                    w_count_d = 16'd0;
                end else begin
                    w_count_d = r_count + 16'd1;
                end
            end
            IFG: begin
                if (r_count == IFG_LAST) begin
                    w_state_d  = IDLE;
                    w_count_d  = 16'd0;
                    w_crc_init = 1'b1;
                end else begin
                    w_count_d = r_count + 16'd1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Output registers load the nibble belonging to the next state, so the wire
    // always reflects the registered state one cycle after the decision.
    always_comb begin
        w_nibble_d = 4'h0;
        w_valid_d  = 1'b0;
        w_done_d   = 1'b0;
        case (w_state_d)
            PREAMBLE: begin
                w_valid_d  = 1'b1;
                w_nibble_d = (w_count_d == 16'd15) ? SFD_NIBBLE : PREAMBLE_NIBBLE;
            end
            PAYLOAD: begin
                w_valid_d  = 1'b1;
                w_nibble_d = w_phase_d ? w_hold_d[7:4] : w_hold_d[3:0];
            end
            PAD: w_valid_d = 1'b1;
            FCS: begin
                w_valid_d  = 1'b1;
                w_nibble_d = w_fcs[{w_count_d[2:0], 2'b00} +: 4];
                w_done_d   = (w_count_d == 16'd7);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_hold       <= 9'h0;
            r_byte_count <= 11'd0;
            r_phase      <= 1'b0;
            r_count      <= 16'd0;
            r_phy_data   <= 4'h0;
            r_phy_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_hold       <= w_hold_d;
            r_byte_count <= w_byte_count_d;
            r_phase      <= w_phase_d;
            r_count      <= w_count_d;
            r_phy_data   <= w_nibble_d;
            r_phy_valid  <= w_valid_d;
            r_done       <= w_done_d;
            r_abort      <= w_abort_d;
        end
    end

    assign o_phy_transmit_data       = r_phy_data;
    assign o_phy_transmit_data_valid = r_phy_valid;
    assign o_frame_done              = r_done;
    assign o_frame_abort             = r_abort;

endmodule

// File: tb/tb_ethernet_packet_transmitter.sv
// Directed bench: three transmitter instances (MIN=1, defaults, MAX=64) share one byte source.
module tb_ethernet_packet_transmitter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] tx_data;
    logic       tx_en;
    logic       en_a, en_b, en_c;
    logic       rdy_a, val_a, done_a, abort_a;
    logic       rdy_b, val_b, done_b, abort_b;
    logic       rdy_c, val_c, done_c, abort_c;
    logic [3:0] dat_a, dat_b, dat_c;

    int vectors = 0;
    int errors  = 0;

    logic [8:0] src[$];
    logic       cap_r[$], cap_v[$], cap_dn[$], cap_ab[$];
    logic [3:0] cap_d[$];
    logic [3:0] vn[$];
    int         xfer_at[$];

    always #5 clk = ~clk;

    ethernet_packet_transmitter #(.MIN_FRAME_BYTES(1)) dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(en_a), .i_transmit_data(tx_data),
        .i_transmit_data_enable(tx_en), .o_transmit_data_ready(rdy_a),
        .o_phy_transmit_data(dat_a), .o_phy_transmit_data_valid(val_a),
        .o_frame_done(done_a), .o_frame_abort(abort_a)
    );

    ethernet_packet_transmitter dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(en_b), .i_transmit_data(tx_data),
        .i_transmit_data_enable(tx_en), .o_transmit_data_ready(rdy_b),
        .o_phy_transmit_data(dat_b), .o_phy_transmit_data_valid(val_b),
        .o_frame_done(done_b), .o_frame_abort(abort_b)
    );

    ethernet_packet_transmitter #(.MAX_FRAME_BYTES(64)) dut_c (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(en_c), .i_transmit_data(tx_data),
        .i_transmit_data_enable(tx_en), .o_transmit_data_ready(rdy_c),
        .o_phy_transmit_data(dat_c), .o_phy_transmit_data_valid(val_c),
        .o_frame_done(done_c), .o_frame_abort(abort_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel, output logic r, output logic v, output logic dn,
                          output logic ab, output logic [3:0] d);
        case (sel)
            0:       begin r = rdy_a; v = val_a; dn = done_a; ab = abort_a; d = dat_a; end
            1:       begin r = rdy_b; v = val_b; dn = done_b; ab = abort_b; d = dat_b; end
            default: begin r = rdy_c; v = val_c; dn = done_c; ab = abort_c; d = dat_c; end
        endcase
    endtask

    // Plays src into the selected DUT for ncycles, recording outputs at each negedge.
    task automatic run(input int sel, input int ncycles);
        int         idx;
        logic       r, v, dn, ab;
        logic [3:0] d;
        idx = 0;
        cap_r.delete(); cap_v.delete(); cap_dn.delete(); cap_ab.delete();
        cap_d.delete(); vn.delete(); xfer_at.delete();
        for (int k = 0; k < ncycles; k++) begin
            @(negedge clk);
            sample(sel, r, v, dn, ab, d);
            cap_r.push_back(r); cap_v.push_back(v); cap_dn.push_back(dn);
            cap_ab.push_back(ab); cap_d.push_back(d);
            if (v) vn.push_back(d);
            tx_en   = (idx < src.size());
            tx_data = (idx < src.size()) ? src[idx] : 9'h0;
            if (r && tx_en) begin
                xfer_at.push_back(k);
                idx++;
            end
        end
        tx_en = 1'b0;
    endtask

    function automatic int first_of(input int which);
        for (int k = 0; k < cap_v.size(); k++) begin
            if ((which == 0 && cap_v[k]) || (which == 1 && cap_dn[k]) ||
                (which == 2 && cap_ab[k])) return k;
        end
        return -1;
    endfunction

    function automatic int last_valid();
        int l = -1;
        for (int k = 0; k < cap_v.size(); k++) if (cap_v[k]) l = k;
        return l;
    endfunction

    function automatic int count_of(input int which, input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi && k < cap_v.size(); k++) begin
            if (k >= 0 && ((which == 0 && cap_v[k]) || (which == 1 && cap_dn[k]) ||
                           (which == 2 && cap_ab[k]) || (which == 3 && cap_r[k]))) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] fcs_at(input int base);
        logic [31:0] f = 32'h0;
        for (int i = 0; i < 8; i++) f[4*i +: 4] = vn[base + i];
        return f;
    endfunction

    // Bit-serial reference FCS over payload+pad bytes.
    function automatic logic [31:0] model_fcs(input logic [7:0] bytes_q[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic        fb;
        foreach (bytes_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ bytes_q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic check_preamble(input string tag);
        int bad = 0;
        for (int i = 0; i < 15; i++) if (vn[i] !== 4'h5) bad++;
        check({tag, "_preamble"}, bad, 0);
        check({tag, "_sfd"}, vn[15], 4'hD);
    endtask

    initial begin
        logic [7:0] mq[$];
        logic [3:0] exp_nib[$];
        int         l, a, d1, s2, bad;

        rst_n = 1'b0; tx_en = 1'b0; tx_data = 9'h0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        @(negedge clk);
        check("reset_valid", {val_a, val_b, val_c}, 3'b000);
        check("reset_data", {dat_a, dat_b, dat_c}, 12'h000);
        check("reset_pulses", {done_a, abort_a, done_b, abort_b, done_c, abort_c}, 6'h0);
        check("reset_ready", {rdy_a, rdy_b, rdy_c}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        en_a  = 1'b1;
        @(negedge clk);
        check("idle_ready", rdy_a, 1'b1);

        // "123456789" with MIN=1: CRC check value 0xCBF43926.
        src.delete();
        for (int i = 0; i < 9; i++) src.push_back({(i == 8), 8'(8'h31 + i)});
        run(0, 80);
        check("t1_xfers", xfer_at.size(), 9);
        check("t1_latency", first_of(0), xfer_at[0] + 1);
        check("t1_nibbles", vn.size(), 42);
        exp_nib.delete();
        for (int i = 0; i < 15; i++) exp_nib.push_back(4'h5);
        exp_nib.push_back(4'hD);
        for (int i = 1; i <= 9; i++) begin
            exp_nib.push_back(4'(i));
            exp_nib.push_back(4'h3);
        end
        exp_nib.push_back(4'h6); exp_nib.push_back(4'h2); exp_nib.push_back(4'h9);
        exp_nib.push_back(4'h3); exp_nib.push_back(4'h4); exp_nib.push_back(4'hF);
        exp_nib.push_back(4'hB); exp_nib.push_back(4'hC);
        for (int i = 0; i < 42; i++) check($sformatf("t1_nib%0d", i), vn[i], exp_nib[i]);
        l = last_valid();
        check("t1_done_pos", first_of(1), l);
        check("t1_done_cnt", count_of(1, 0, 79), 1);
        check("t1_ifg_valid", count_of(0, l + 1, l + 24), 0);
        check("t1_ifg_ready_end", cap_r[l + 24], 1'b0);
        check("t1_idle_ready", cap_r[l + 25], 1'b1);
        en_a = 1'b0;

        // 10 bytes with defaults: 50 pad bytes, 144 valid cycles.
        en_b = 1'b1;
        src.delete(); mq.delete();
        for (int i = 0; i < 10; i++) begin
            src.push_back({(i == 9), 8'(8'hA0 + i)});
            mq.push_back(8'(8'hA0 + i));
        end
        for (int i = 0; i < 50; i++) mq.push_back(8'h00);
        run(1, 180);
        check("t2_valid_cycles", count_of(0, 0, 179), 144);
        check_preamble("t2");
        check("t2_payload_first", {vn[17], vn[16]}, 8'hA0);
        check("t2_payload_last", {vn[35], vn[34]}, 8'hA9);
        bad = 0;
        for (int i = 36; i < 136; i++) if (vn[i] !== 4'h0) bad++;
        check("t2_pad_zero", bad, 0);
        check("t2_fcs", fcs_at(136), model_fcs(mq));
        l = last_valid();
        check("t2_done_pos", first_of(1), l);
        a = first_of(0);
        check("t2_ready_preamble", count_of(3, a, a + 15), 0);
        check("t2_ready_pad_fcs", count_of(3, a + 36, l), 0);

        // Underrun: source stops after 4 bytes, no last flag.
        src.delete();
        for (int i = 0; i < 4; i++) src.push_back({1'b0, 8'(8'h10 + i)});
        run(1, 60);
        check("t3_valid_cycles", count_of(0, 0, 59), 24);
        a = first_of(2);
        check("t3_abort_pos", a, last_valid() + 1);
        check("t3_abort_cnt", count_of(2, 0, 59), 1);
        check("t3_done_cnt", count_of(1, 0, 59), 0);
        check("t3_ifg_ready", count_of(3, a, a + 23), 0);
        check("t3_ready_again", cap_r[a + 24], 1'b1);
        en_b = 1'b0;

        // Oversize with MAX=64: 65th transfer aborts.
        en_c = 1'b1;
        src.delete();
        for (int i = 0; i < 65; i++) src.push_back({1'b0, 8'(i)});
        run(2, 200);
        check("t4_xfers", xfer_at.size(), 65);
        check("t4_valid_cycles", count_of(0, 0, 199), 144);
        check("t4_abort_cnt", count_of(2, 0, 199), 1);
        check("t4_abort_pos", first_of(2), last_valid() + 1);
        check("t4_done_cnt", count_of(1, 0, 199), 0);
        en_c = 1'b0;

        // Back-to-back 10-byte frames, source always ready.
        en_b = 1'b1;
        src.delete();
        for (int i = 0; i < 20; i++) src.push_back({(i == 9 || i == 19), 8'(8'h40 + i)});
        run(1, 350);
        check("t5_done_cnt", count_of(1, 0, 349), 2);
        check("t5_valid_cycles", count_of(0, 0, 349), 288);
        d1 = first_of(1);
        s2 = -1;
        for (int k = d1 + 1; k < 350 && s2 < 0; k++) if (cap_v[k]) s2 = k;
        check("t5_gap_ge24", (s2 - d1 - 1) >= 24, 1'b1);
        check("t5_ifg_ready", count_of(3, d1 + 1, d1 + 24), 0);
        check("t5_ready_preamble2", count_of(3, s2, s2 + 15), 0);

        // Reset during payload, then a fresh 1-byte frame.
        src.delete();
        for (int i = 0; i < 30; i++) src.push_back({1'b0, 8'(8'h77)});
        run(1, 25);
        check("t6_in_payload", cap_v[24], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_reset_valid", val_b, 1'b0);
        check("t6_reset_data", dat_b, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        src.delete(); mq.delete();
        src.push_back(9'h15A);
        mq.push_back(8'h5A);
        for (int i = 0; i < 59; i++) mq.push_back(8'h00);
        run(1, 180);
        check("t6_latency", first_of(0), 1);
        check_preamble("t6");
        check("t6_payload", {vn[17], vn[16]}, 8'h5A);
        check("t6_valid_cycles", count_of(0, 0, 179), 144);
        check("t6_fcs", fcs_at(136), model_fcs(mq));
        check("t6_done_cnt", count_of(1, 0, 179), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
